// File: rtl/pc_ras_unit.sv
// Fetch program counter with IDLE/RUN/HALTED control, redirect priority and a
// circular return-address stack used to predict return targets.
module pc_ras_unit #(
  parameter int unsigned         XLEN      = 32,
  parameter logic [XLEN-1:0]     RESET_VEC = '0,
  parameter int unsigned         INC       = 4,
  parameter int unsigned         RAS_DEPTH = 4,
  localparam int unsigned        CW        = $clog2(RAS_DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            halt_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            call_i,
  input  logic [XLEN-1:0] call_pc_i,
  input  logic            ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic            fetch_vld_o,
  output logic [1:0]      state_o,
  output logic [CW-1:0]   ras_cnt_o,
  output logic            ras_ovf_o,
  output logic            ras_unf_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0]     top;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   pc_inc;
  logic              upd_en;
  logic              do_ret;
  logic              do_call;
  logic              ras_empty;
  logic              ras_full;

  assign state_o   = state;
  assign ras_cnt_o = cnt;
  assign pc_inc    = pc_o + XLEN'(INC);
  assign ras_empty = (cnt == '0);
  assign ras_full  = (cnt == CW'(RAS_DEPTH));

  // A PC update happens only in RUN when neither leaving, halting nor stalled;
  // redirect then outranks return, which outranks call.
  assign upd_en  = (state == RUN) && start_i && !halt_i && !stall_i;
  assign do_ret  = upd_en && !redirect_i && ret_i;
  assign do_call = upd_en && !redirect_i && !ret_i && call_i;

  // Stack storage has no reset; validity is tracked by cnt alone.
  always_ff @(posedge clk_i) begin
    if (do_call) begin
      ras_mem[top + PW'(1)] <= pc_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pc_o        <= RESET_VEC;
      fetch_vld_o <= 1'b0;
      top         <= '0;
      cnt         <= '0;
      ras_ovf_o   <= 1'b0;
      ras_unf_o   <= 1'b0;
    end else begin
      ras_ovf_o <= 1'b0;
      ras_unf_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state       <= RUN;
            fetch_vld_o <= 1'b1;
          end
        end
        RUN: begin
          if (!start_i) begin
            state       <= IDLE;
            fetch_vld_o <= 1'b0;
            pc_o        <= RESET_VEC;
            cnt         <= '0;
          end else if (halt_i) begin
            state       <= HALTED;
            fetch_vld_o <= 1'b0;
          end else if (!stall_i) begin
            if (redirect_i) begin
              pc_o <= redirect_pc_i;
            end else if (ret_i) begin
              if (!ras_empty) begin
                pc_o <= ras_mem[top];
                top  <= top - PW'(1);
                cnt  <= cnt - CW'(1);
              end else begin
                pc_o      <= pc_inc;
                ras_unf_o <= 1'b1;
              end
            end else if (call_i) begin
              // When full, the push lands on the oldest slot and cnt saturates.
              pc_o <= call_pc_i;
              top  <= top + PW'(1);
              if (ras_full) begin
                ras_ovf_o <= 1'b1;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else begin
              pc_o <= pc_inc;
            end
          end
        end
        HALTED: begin
          if (!start_i) begin
            state       <= IDLE;
            fetch_vld_o <= 1'b0;
            pc_o        <= RESET_VEC;
            cnt         <= '0;
          end else if (!halt_i) begin
            state       <= RUN;
            fetch_vld_o <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          fetch_vld_o <= 1'b0;
          pc_o        <= RESET_VEC;
          cnt         <= '0;
        end
      endcase
    end
  end

  logic unused_do_ret;
  assign unused_do_ret = do_ret;

endmodule
